// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the dual-way fetch front end.
//   - fetch_state_e     : fetch FSM states (IDLE, REQ, WAIT, HOLD)
//   - FETCH_BLOCK_BYTES : size of one instruction-pair block in bytes
//   - FETCH_RESET_PC    : default program counter loaded at reset
//   - block_addr()      : aligns a PC down to its 8-byte block
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam int unsigned FETCH_BLOCK_BYTES = 8;
    localparam logic [31:0] FETCH_RESET_PC    = 32'h8000_0000;

    function automatic logic [31:0] block_addr(input logic [31:0] pc);
        return {pc[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_pair_buf.sv
// ---------------------------------------------------------------------------
// fetch_pair_buf
//   Holds one returned instruction pair until the FSM hands it downstream.
//   Ports:
//     clk, reset_n   : clock, asynchronous active-low reset
//     load_i         : capture data_i / addr_i / skip0_i
//     clear_i        : discard the buffered pair (wins over load_i)
//     data_i/data_o  : 64-bit pair, [31:0] way0, [63:32] way1
//     addr_i/addr_o  : 8-byte aligned block address of the pair
//     skip0_i/skip0_o: the low word precedes the fetch PC and must not issue
// ---------------------------------------------------------------------------
module fetch_pair_buf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [63:0] data_i,
    input  logic [31:0] addr_i,
    input  logic        skip0_i,
    output logic [63:0] data_o,
    output logic [31:0] addr_o,
    output logic        skip0_o
);

    logic [63:0] data_q;
    logic [31:0] addr_q;
    logic        skip0_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            addr_q  <= '0;
            skip0_q <= 1'b0;
        end else if (clear_i) begin
            data_q  <= '0;
            addr_q  <= '0;
            skip0_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            addr_q  <= addr_i;
            skip0_q <= skip0_i;
        end
    end

    assign data_o  = data_q;
    assign addr_o  = addr_q;
    assign skip0_o = skip0_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//   Dual-way fetch front end. Owns the PC, requests 8-byte aligned pairs from
//   instruction memory, buffers each response and delivers it in lockstep:
//   low word to way0, high word to way1. Redirects restart fetch at a new PC
//   and discard any response still in flight.
//
//   Handshakes:
//     memory  : mem_req_o/mem_addr_o are held until a cycle with mem_gnt_i;
//               each grant is answered by exactly one mem_rvalid_i cycle.
//     ways    : way*_valid_o pulse only in HOLD when both way*_ready_i are
//               high and no redirect is present; the ways write on valid
//               without re-checking ready.
//
//   Ports:
//     clk, reset_n              : clock, asynchronous active-low reset
//     redirect_i, redirect_pc_i : single-cycle redirect and its target
//     mem_req_o, mem_addr_o     : fetch request (registered)
//     mem_gnt_i                 : request accepted
//     mem_rvalid_i, mem_rdata_i : response
//     way0_* / way1_*           : per-way valid, instruction, address, ready
//     dbg_state_o, dbg_pc_o     : FSM state and current PC for observation
//   Optional (FETCH_PERF_CNT_EN defined):
//     perf_pair_cnt_o           : transfers made
//     perf_drop_cnt_o           : discarded responses plus discarded buffers
// ---------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         mem_req_o,
    output logic [31:0]  mem_addr_o,
    input  logic         mem_gnt_i,
    input  logic         mem_rvalid_i,
    input  logic [63:0]  mem_rdata_i,
    output logic         way0_valid_o,
    output logic [31:0]  way0_inst_o,
    output logic [31:0]  way0_addr_o,
    input  logic         way0_ready_i,
    output logic         way1_valid_o,
    output logic [31:0]  way1_inst_o,
    output logic [31:0]  way1_addr_o,
    input  logic         way1_ready_i,
    output fetch_state_e dbg_state_o,
    output logic [31:0]  dbg_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_pair_cnt_o,
    output logic [31:0]  perf_drop_cnt_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic         mem_req_q, mem_req_d;
    logic [31:0]  mem_addr_q, mem_addr_d;

    // Last values shown to the ways, so inst/addr hold outside HOLD.
    logic [31:0]  out_inst0_q, out_inst1_q, out_addr0_q, out_addr1_q;

    logic         buf_load, buf_clear, xfer;
    logic [63:0]  buf_data;
    logic [31:0]  buf_addr;
    logic         buf_skip0;

    fetch_pair_buf u_pair_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (mem_rdata_i),
        .addr_i  (mem_addr_q),
        .skip0_i (pc_q[2]),
        .data_o  (buf_data),
        .addr_o  (buf_addr),
        .skip0_o (buf_skip0)
    );

    // Next-state logic. drop_q marks the one outstanding request whose
    // response must be thrown away because a redirect overtook it.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_i) begin
                    pc_d      = redirect_pc_i;
                    buf_clear = 1'b1;
                end
            end
            REQ: begin
                // The address already on the bus stays put; its response is
                // marked for discard instead.
                if (redirect_i) begin
                    pc_d   = redirect_pc_i;
                    drop_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
                if (mem_rvalid_i) begin
                    if (drop_q || redirect_i) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_d      = redirect_pc_i;
                    buf_clear = 1'b1;
                    state_d   = REQ;
                end else if (way0_ready_i && way1_ready_i) begin
                    xfer    = 1'b1;
                    pc_d    = block_addr(pc_q) + 32'(FETCH_BLOCK_BYTES);
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_req_d = (state_d == REQ);
        // Address is captured only on entry to REQ so it is stable until gnt.
        if ((state_d == REQ) && (state_q != REQ)) begin
            mem_addr_d = block_addr(pc_d);
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            out_inst0_q <= '0;
            out_inst1_q <= '0;
            out_addr0_q <= '0;
            out_addr1_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            if (state_q == HOLD) begin
                out_inst0_q <= buf_data[31:0];
                out_inst1_q <= buf_data[63:32];
                out_addr0_q <= buf_addr;
                out_addr1_q <= buf_addr + 32'd4;
            end
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    // A pair fetched from an odd-word PC only issues its high word.
    assign way0_valid_o = xfer && !buf_skip0;
    assign way1_valid_o = xfer;

    assign way0_inst_o = (state_q == HOLD) ? buf_data[31:0]   : out_inst0_q;
    assign way1_inst_o = (state_q == HOLD) ? buf_data[63:32]  : out_inst1_q;
    assign way0_addr_o = (state_q == HOLD) ? buf_addr          : out_addr0_q;
    assign way1_addr_o = (state_q == HOLD) ? buf_addr + 32'd4  : out_addr1_q;

    assign dbg_state_o = state_q;
    assign dbg_pc_o    = pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic        drop_evt;
    logic [31:0] pair_cnt_q, drop_cnt_q;

    // A discarded response or a discarded buffered pair.
    assign drop_evt = ((state_q == WAIT) && mem_rvalid_i && (drop_q || redirect_i)) ||
                      ((state_q == HOLD) && redirect_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (xfer) begin
                pair_cnt_q <= pair_cnt_q + 32'd1;
            end
            if (drop_evt) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign perf_pair_cnt_o = pair_cnt_q;
    assign perf_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;
    import fetch_pkg::*;

    localparam int W = 130;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- main DUT ----------------
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [63:0]  mem_rdata_i;
    logic         way0_valid_o, way1_valid_o;
    logic [31:0]  way0_inst_o, way0_addr_o, way1_inst_o, way1_addr_o;
    logic         way0_ready_i, way1_ready_i;
    fetch_state_e dbg_state;
    logic [31:0]  dbg_pc;

    fetch_pc_gen u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .way0_valid_o  (way0_valid_o),
        .way0_inst_o   (way0_inst_o),
        .way0_addr_o   (way0_addr_o),
        .way0_ready_i  (way0_ready_i),
        .way1_valid_o  (way1_valid_o),
        .way1_inst_o   (way1_inst_o),
        .way1_addr_o   (way1_addr_o),
        .way1_ready_i  (way1_ready_i),
        .dbg_state_o   (dbg_state),
        .dbg_pc_o      (dbg_pc)
    );

    // ---------------- second DUT: reset PC at top of address space ----------
    logic         b_reset_n, b_rvalid, b_pend;
    logic         b_req, b_v0, b_v1;
    logic [31:0]  b_addr, b_i0, b_i1, b_a0, b_a1, b_pc;
    fetch_state_e b_state;

    fetch_pc_gen #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
        .clk           (clk),
        .reset_n       (b_reset_n),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .mem_req_o     (b_req),
        .mem_addr_o    (b_addr),
        .mem_gnt_i     (1'b1),
        .mem_rvalid_i  (b_rvalid),
        .mem_rdata_i   (64'hDEAD_BEEF_CAFE_F00D),
        .way0_valid_o  (b_v0),
        .way0_inst_o   (b_i0),
        .way0_addr_o   (b_a0),
        .way0_ready_i  (1'b1),
        .way1_valid_o  (b_v1),
        .way1_inst_o   (b_i1),
        .way1_addr_o   (b_a1),
        .way1_ready_i  (1'b1),
        .dbg_state_o   (b_state),
        .dbg_pc_o      (b_pc)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  exp_addr_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic v0, input logic v1,
                                        input logic [31:0] i0, input logic [31:0] a0,
                                        input logic [31:0] i1, input logic [31:0] a1);
        return {v0, v1, i0, a0, i1, a1};
    endfunction

    // Monitor: granted requests and way transfers are popped and compared.
    always @(negedge clk) begin
        if (mem_req_o && mem_gnt_i) begin
            if (exp_addr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_unexpected: got addr %h, none expected", mem_addr_o);
            end else begin
                check("req_addr", W'(mem_addr_o), W'(exp_addr_q.pop_front()));
            end
        end
        if (way0_valid_o || way1_valid_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL xfer_unexpected: got v0=%b v1=%b a0=%h, none expected",
                         way0_valid_o, way1_valid_o, way0_addr_o);
            end else begin
                check("xfer_pair", mk(way0_valid_o, way1_valid_o, way0_inst_o, way0_addr_o,
                                      way1_inst_o, way1_addr_o), exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req_o && n < 20) begin
            step();
            n++;
        end
        if (!mem_req_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: got no mem_req_o within 20 cycles, required a request");
        end
    endtask

    // Grant one request, return data one cycle later, then optionally
    // redirect in the HOLD cycle. Leaves time inside the HOLD cycle.
    task automatic run_pair(input logic [63:0] data, input logic expect_now,
                            input logic redir, input logic [31:0] rpc);
        wait_req();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        step();
        mem_rvalid_i = 1'b0;
        if (redir) begin
            redirect_i    = 1'b1;
            redirect_pc_i = rpc;
        end
        #1;
        check("xfer_latency", W'(way1_valid_o), W'(expect_now));
    endtask

    // Second-DUT capture state
    int           b_nreq;
    logic [31:0]  b_req_addr [2];
    logic         b_seen;
    logic [31:0]  b_seen_a0, b_seen_a1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n       = 1'b0;
        b_reset_n     = 1'b0;
        b_rvalid      = 1'b0;
        b_pend        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        way0_ready_i  = 1'b1;
        way1_ready_i  = 1'b1;
        b_nreq        = 0;
        b_seen        = 1'b0;
        b_req_addr[0] = 32'h1;
        b_req_addr[1] = 32'h1;
        b_seen_a0     = 32'h1;
        b_seen_a1     = 32'h1;

        // Reset state
        step();
        step();
        check("rst_req",   W'(mem_req_o), W'(1'b0));
        check("rst_addr",  W'(mem_addr_o), W'(32'h0));
        check("rst_ways",  mk(way0_valid_o, way1_valid_o, way0_inst_o, way0_addr_o,
                              way1_inst_o, way1_addr_o), '0);
        check("rst_pc",    W'(dbg_pc), W'(32'h8000_0000));
        check("rst_state", W'(dbg_state), W'(IDLE));

        // First request on the first edge after release
        reset_n = 1'b1;
        step();
        check("first_req", W'({mem_req_o, mem_addr_o}), W'({1'b1, 32'h8000_0000}));

        // Basic pair
        exp_addr_q.push_back(32'h8000_0000);
        exp_q.push_back(mk(1'b1, 1'b1, 32'h93, 32'h8000_0000, 32'h13, 32'h8000_0004));
        run_pair(64'h0000_0013_0000_0093, 1'b1, 1'b0, 32'h0);
        step();
        check("next_addr", W'({mem_req_o, mem_addr_o}), W'({1'b1, 32'h8000_0008}));

        // way1 not ready for 5 HOLD cycles
        exp_addr_q.push_back(32'h8000_0008);
        exp_q.push_back(mk(1'b1, 1'b1, 32'hCCCC_DDDD, 32'h8000_0008, 32'hAAAA_BBBB, 32'h8000_000C));
        way1_ready_i = 1'b0;
        run_pair(64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_no_valid", W'({way0_valid_o, way1_valid_o}), W'(2'b00));
        end
        way1_ready_i = 1'b1;
        step();

        // Redirect during WAIT: response discarded
        exp_addr_q.push_back(32'h8000_0010);
        wait_req();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i     = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        step();
        redirect_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        mem_rvalid_i = 1'b0;
        check("drop_no_valid", W'({way0_valid_o, way1_valid_o}), W'(2'b00));
        check("redir_addr", W'({mem_req_o, mem_addr_o}), W'({1'b1, 32'h8000_0100}));
        exp_addr_q.push_back(32'h8000_0100);
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_0513, 32'h8000_0100, 32'h0000_0593, 32'h8000_0104));
        run_pair(64'h0000_0593_0000_0513, 1'b1, 1'b0, 32'h0);
        step();

        // Redirect to an odd word while a request waits for grant
        exp_addr_q.push_back(32'h8000_0108);
        wait_req();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0204;
        step();
        redirect_i = 1'b0;
        check("addr_stable", W'({mem_req_o, mem_addr_o}), W'({1'b1, 32'h8000_0108}));
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        check("redir_blk_addr", W'({mem_req_o, mem_addr_o}), W'({1'b1, 32'h8000_0200}));
        exp_addr_q.push_back(32'h8000_0200);
        exp_q.push_back(mk(1'b0, 1'b1, 32'h3333_4444, 32'h8000_0200, 32'h1111_2222, 32'h8000_0204));
        run_pair(64'h1111_2222_3333_4444, 1'b1, 1'b0, 32'h0);
        step();
        check("skip_next_addr", W'({mem_req_o, mem_addr_o}), W'({1'b1, 32'h8000_0208}));

        // Redirect coincident with a would-be transfer: pair lost
        exp_addr_q.push_back(32'h8000_0208);
        run_pair(64'h9999_8888_7777_6666, 1'b0, 1'b1, 32'h8000_0300);
        step();
        redirect_i = 1'b0;
        check("xfer_redir_addr", W'({mem_req_o, mem_addr_o}), W'({1'b1, 32'h8000_0300}));

        // Reset during WAIT, stale rvalid afterwards
        exp_addr_q.push_back(32'h8000_0300);
        wait_req();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("reset_mid", W'({mem_req_o, dbg_state}), W'({1'b0, IDLE}));
        step();
        reset_n      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        check("restart_addr", W'({mem_req_o, mem_addr_o}), W'({1'b1, 32'h8000_0000}));
        step();
        mem_rvalid_i = 1'b0;
        check("stale_ignored", W'({way0_valid_o, way1_valid_o, dbg_state}), W'({2'b00, REQ}));
        exp_addr_q.push_back(32'h8000_0000);
        exp_q.push_back(mk(1'b1, 1'b1, 32'h7777_8888, 32'h8000_0000, 32'h5555_6666, 32'h8000_0004));
        run_pair(64'h5555_6666_7777_8888, 1'b1, 1'b0, 32'h0);
        step();
        step();
        check("sb_drain", W'(exp_q.size() + exp_addr_q.size()), W'(0));

        // Reset PC wrap on the second DUT
        b_reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b_req && b_nreq < 2) begin
                b_req_addr[b_nreq] = b_addr;
                b_nreq++;
            end
            if ((b_v0 || b_v1) && !b_seen) begin
                b_seen    = 1'b1;
                b_seen_a0 = b_a0;
                b_seen_a1 = b_a1;
            end
            b_pend = b_req;
            @(posedge clk);
            #1;
            b_rvalid = b_pend;
        end
        check("wrap_first_req", W'(b_req_addr[0]), W'(32'hFFFF_FFF8));
        check("wrap_xfer", W'({b_seen, b_seen_a0, b_seen_a1}),
              W'({1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC}));
        check("wrap_next_req", W'(b_req_addr[1]), W'(32'h0000_0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Dual-way fetch front end: owns the program counter, issues 8-byte aligned instruction-pair requests to instruction memory, and buffers each returned pair. It sits directly upstream of the way0/way1 instruction fetch units. Each pair goes out in lockstep: low word to way0, high word to way1. Redirects (branch/flush) restart fetch at a new PC and discard any in-flight response.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded at reset. Must be 4-byte aligned.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- redirect_i  in  1  redirect request, single-cycle
- redirect_pc_i  in  32  redirect target, 4-byte aligned
- mem_req_o  out  1  fetch request
- mem_addr_o  out  32  request address; bits [2:0] always 0
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid, one cycle per granted request
- mem_rdata_i  in  64  response; [31:0] goes to way0, [63:32] goes to way1
- way0_valid_o / way1_valid_o  out  1  slot valid, single-cycle pulse
- way0_inst_o / way1_inst_o  out  32  instruction
- way0_addr_o / way1_addr_o  out  32  instruction address (block, block+4)
- way0_ready_i / way1_ready_i  in  1  downstream can accept (not full)

## Operation
- Registers:
  - pc (32)
  - state
  - drop flag
  - pair buffer: data 64, block address 32, skip0 bit
- States:
  - IDLE: entered at reset; goes to REQ next cycle unconditionally.
  - REQ: mem_req_o=1, mem_addr_o={pc[31:3],3'b0}. On gnt go to WAIT. mem_addr_o stays stable until gnt.
  - WAIT: on mem_rvalid_i, either discard the response (drop=1, clear drop, go to REQ) or load the buffer and go to HOLD.
  - HOLD: wait until both readies are high, then transfer, advance pc to {pc[31:3],3'b0}+8 (wraps mod 2^32), and go to REQ.
- Transfer rule: valid pulses only when state==HOLD, way0_ready_i, way1_ready_i and !redirect_i all hold. Valids are never asserted otherwise; downstream writes on valid without checking its own ready.
- skip0: set when the buffered block was fetched with pc[2]=1. During transfer, way0_valid_o=0 and way1_valid_o=1. skip0 clears for the next block.
- Redirect (always wins; pc<=redirect_pc_i):
  - IDLE or HOLD: buffer discarded, go to REQ next cycle.
  - REQ without gnt: mem_addr_o stays stable. The current request completes, then drop=1.
  - REQ with gnt same cycle: go to WAIT with drop=1.
  - WAIT: drop=1; if mem_rvalid_i is high the same cycle, the response is discarded and the next state is REQ.
- Redirect coincident with transfer: transfer is suppressed and the pair is lost.
- A second redirect while drop=1 only updates pc. At most one request is outstanding.

## Timing
- Reset values:
  - mem_req_o=0, mem_addr_o=0
  - both valids=0, insts/addrs=0
  - pc=RESET_PC, drop=0, state IDLE
- First mem_req_o: first clk edge after reset_n deasserts.
- Latency: gnt in the same cycle as req; rvalid at the earliest one cycle after gnt; valid pulse at the earliest in the cycle after rvalid.
- Zero-wait throughput: one pair every 3 cycles.
- way*_addr_o and way*_inst_o are driven from the buffer while in HOLD and hold their values otherwise.
- Reset mid-operation clears the state immediately. A later rvalid belonging to the pre-reset request is ignored outside WAIT.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: adds ports perf_pair_cnt_o[31:0] (transfers) and perf_drop_cnt_o[31:0] (discarded responses plus discarded buffers). Both reset to 0, increment by 1, and wrap.
  - Undefined: these ports and their counters are absent.

## Structure
- Package fetch_pkg holds:
  - state enum (IDLE, REQ, WAIT, HOLD)
  - FETCH_BLOCK_BYTES=8
  - default RESET_PC constant
- One sub-module, fetch_pair_buf: load/clear/hold register for data, block address and skip0. The FSM and pc stay in the top.

## Test plan
- Reset, gnt same cycle, rvalid one cycle later with data 64'h0000_0013_0000_0093 -> way0 gets 0x93 @0x8000_0000, way1 gets 0x13 @0x8000_0004, valids pulse in the cycle after rvalid; next mem_addr_o=0x8000_0008.
- way1_ready_i=0 for 5 cycles while in HOLD -> no valid for those 5 cycles; single pulse once both readies are high.
- Redirect to 0x8000_0100 during WAIT -> the following rvalid is discarded, no valid pulse, next request addr=0x8000_0100.
- Redirect to 0x8000_0204 -> request addr=0x8000_0200; transfer has way0_valid_o=0, way1_valid_o=1, way1_addr_o=0x8000_0204; next addr=0x8000_0208.
- RESET_PC=32'hFFFF_FFF8 -> after the first transfer, next mem_addr_o=0x0000_0000.
- Redirect in the same cycle as a would-be transfer, and reset_n low during WAIT -> no valid pulse in either case; after reset, req restarts at RESET_PC and the stale rvalid is ignored.
